// File: rtl/soc_periph_pkg.sv
// Shared constants for the chip-select/strobe peripheral bus.
package soc_periph_pkg;

    localparam int unsigned BUS_W  = 16;
    localparam int unsigned ADDR_W = 2;

    localparam logic [ADDR_W-1:0] ADDR_DATA  = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_BLINK = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_SET   = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_CLEAR = 2'd3;

endpackage

// File: rtl/blink_timer.sv
// Free-running blink divider: phase toggles every BLINK_DIV clocks; restart forces count and phase to 0.
module blink_timer #(
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic iClk,
    input  logic iReset_n,
    input  logic restart,
    output logic phase
);

    localparam int unsigned CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            count <= '0;
            phase <= 1'b0;
        end else if (restart) begin
            count <= '0;
            phase <= 1'b0;
        end else if (count == CNT_MAX) begin
            count <= '0;
            phase <= ~phase;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/leds_output.sv
// Bus-writable LED port: pattern, atomic set/clear, per-LED blink mask, registered pins and readback.
module leds_output
    import soc_periph_pkg::*;
#(
    parameter int unsigned LED_WIDTH = 10,
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic                 iClk,
    input  logic                 iReset_n,
    input  logic                 iChip_select_n,
    input  logic                 iWrite_n,
    input  logic                 iRead_n,
    input  logic [1:0]           iAddress,
    input  logic [15:0]          iWrite_data,
    output logic [15:0]          oRead_data,
    output logic [LED_WIDTH-1:0] oLeds
);

    logic                 wr_en;
    logic                 rd_en;
    logic                 restart;
    logic                 phase;
    logic [LED_WIDTH-1:0] wdata;
    logic [LED_WIDTH-1:0] data_q;
    logic [LED_WIDTH-1:0] blink_q;
    logic [LED_WIDTH-1:0] display_c;
    logic [BUS_W-1:0]     read_mux_c;
    logic                 unused_wdata;

    assign wr_en   = !iChip_select_n && !iWrite_n;
    assign rd_en   = !iChip_select_n && !iRead_n;
    assign restart = wr_en && (iAddress == ADDR_BLINK);
    assign wdata   = iWrite_data[LED_WIDTH-1:0];
    // Write-data bits above LED_WIDTH are deliberately dropped.
    assign unused_wdata = ^iWrite_data;

    blink_timer #(
        .BLINK_DIV (BLINK_DIV)
    ) u_blink_timer (
        .iClk     (iClk),
        .iReset_n (iReset_n),
        .restart  (restart),
        .phase    (phase)
    );

    // Register file writes.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            data_q  <= '0;
            blink_q <= '0;
        end else if (wr_en) begin
            case (iAddress)
                ADDR_DATA:  data_q  <= wdata;
                ADDR_BLINK: blink_q <= wdata;
                ADDR_SET:   data_q  <= data_q | wdata;
                ADDR_CLEAR: data_q  <= data_q & ~wdata;
                default:    data_q  <= data_q;
            endcase
        end
    end

    // Blinking LEDs are dark while phase is high.
    always_comb begin
        display_c = data_q & ~(blink_q & {LED_WIDTH{phase}});
    end

    // Readback source uses pre-edge state, so a same-cycle write is not visible.
    always_comb begin
        read_mux_c = '0;
        case (iAddress)
            ADDR_DATA:  read_mux_c = BUS_W'(data_q);
            ADDR_BLINK: read_mux_c = BUS_W'(blink_q);
            ADDR_SET:   read_mux_c = BUS_W'(oLeds);
            ADDR_CLEAR: read_mux_c = BUS_W'(phase);
            default:    read_mux_c = '0;
        endcase
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            oLeds      <= '0;
            oRead_data <= '0;
        end else begin
            oLeds <= display_c;
            if (rd_en) begin
                oRead_data <= read_mux_c;
            end
        end
    end

endmodule
